model_input_packer: RTL



---
 rtl/model_packer_pkg.sv | 23 ++
 rtl/model_input_packer_if.sv | 39 +++
 rtl/packer_idle_timer.sv | 55 +++++
 rtl/model_input_packer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/model_packer_pkg.sv
// Shared types and helpers for the model input packer.
// Builds with or without MODEL_PACKER_PARITY_EN; the package itself does not depend on it.
package model_packer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL0 = 2'd1,
        FILL1 = 2'd2,
        HOLD  = 2'd3
    } packer_state_e;

    localparam logic [4:0] DEFAULT_FILL_WORD = 5'h00;

    // Number of positions in a declared range, whichever way it runs.
    function automatic int packer_width(input int left, input int right);
        if (left >= right) begin
            return left - right + 1;
        end else begin
            return right - left + 1;
        end
    endfunction

endpackage

// File: rtl/model_input_packer_if.sv
// Stream-in / word-out bundle between a bit source, the packer and the model feeder.
// out_parity exists only when MODEL_PACKER_PARITY_EN is defined.
interface model_input_packer_if
    import model_packer_pkg::*;
#(
    parameter int LEFT  = 2,
    parameter int RIGHT = -2
);
    logic              in_valid;
    logic              in_ready;
    logic              in_bit;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [LEFT:RIGHT] out_i0;
    logic [RIGHT:LEFT] out_i1;
    logic              out_padded;
`ifdef MODEL_PACKER_PARITY_EN
    logic              out_parity;
`endif

    // Environment side: drives the bit stream and consumes words.
    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_i0, out_i1, out_padded
`ifdef MODEL_PACKER_PARITY_EN
        , input out_parity
`endif
    );

    // Packer side.
    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_i0, out_i1, out_padded
`ifdef MODEL_PACKER_PARITY_EN
        , output out_parity
`endif
    );
endinterface

// File: rtl/packer_idle_timer.sv
// Idle-cycle counter that flags a forced flush of a partial word.
// TIMEOUT=0 removes the counter and never expires.
module packer_idle_timer #(
    parameter int TIMEOUT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_s;
            assign unused_s = ^{clk, rst, active, clear};
            assign expire   = 1'b0;
        end else begin : g_on
            localparam int TW = $clog2(TIMEOUT + 1);
            localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);
            localparam logic [TW-1:0] ONE   = TW'(1);
            localparam logic [TW-1:0] ZERO  = TW'(0);

            logic [TW-1:0] cnt_q;
            logic [TW-1:0] cnt_d;
            logic          expire_s;

            // Expire on the edge where the count would reach TIMEOUT; a clear overrides it.
            always_comb begin
                cnt_d    = cnt_q;
                expire_s = 1'b0;
                if (clear || !active) begin
                    cnt_d = ZERO;
                end else if (cnt_q == LIMIT) begin
                    cnt_d    = ZERO;
                    expire_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            // Counter register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= ZERO;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expire = expire_s;
        end
    endgenerate

endmodule

// File: rtl/model_input_packer.sv
// Deserialises a bit stream into the model's i0 [LEFT:RIGHT] and i1 [RIGHT:LEFT] buses.
// Optional out_parity output is enabled by defining MODEL_PACKER_PARITY_EN.
module model_input_packer
    import model_packer_pkg::*;
#(
    parameter int LEFT  = 2,
    parameter int RIGHT = -2,
    parameter logic [packer_width(LEFT, RIGHT)-1:0] FILL_WORD = DEFAULT_FILL_WORD,
    parameter int FLUSH_TIMEOUT = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    model_input_packer_if.slave  bus
);

    localparam int W  = packer_width(LEFT, RIGHT);
    localparam int CW = $clog2(2 * W + 1);
    localparam logic [CW-1:0] LAST_I0 = CW'(W - 1);
    localparam logic [CW-1:0] LAST_I1 = CW'(2 * W - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] ZERO    = CW'(0);

    packer_state_e state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [W-1:0]  i0_q, i0_d, i1_q, i1_d;
    logic [W-1:0]  place_i0_s, place_i1_s;
    logic          out_valid_q, out_valid_d;
    logic          out_padded_q, out_padded_d;
    logic          in_ready_q, in_ready_d;
    logic          accept_s, fill_active_s, expire_s;

    assign accept_s      = bus.in_valid & bus.in_ready;
    assign fill_active_s = (state_q == FILL0) || (state_q == FILL1);

    packer_idle_timer #(
        .TIMEOUT (FLUSH_TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .active (fill_active_s),
        .clear  (accept_s),
        .expire (expire_s)
    );

    // Staging words with the incoming bit written at the leftmost unfilled position
    // (flat bit W-1 is the left-declared end of either bus).
    always_comb begin
        place_i0_s = i0_q;
        place_i1_s = i1_q;
        for (int j = 0; j < W; j++) begin
            place_i0_s[W-1-j] = (bit_cnt_q == CW'(j))     ? bus.in_bit : i0_q[W-1-j];
            place_i1_s[W-1-j] = (bit_cnt_q == CW'(W + j)) ? bus.in_bit : i1_q[W-1-j];
        end
    end

    // Next-state logic; an accept always takes priority over the idle flush.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        i0_d         = i0_q;
        i1_d         = i1_q;
        out_valid_d  = out_valid_q;
        out_padded_d = out_padded_q;
        case (state_q)
            IDLE, FILL0, FILL1: begin
                if (accept_s) begin
                    i0_d      = place_i0_s;
                    i1_d      = place_i1_s;
                    bit_cnt_d = bit_cnt_q + ONE;
                    if (bus.in_last || (bit_cnt_q == LAST_I1)) begin
                        state_d      = HOLD;
                        out_valid_d  = 1'b1;
                        out_padded_d = (bit_cnt_q != LAST_I1);
                    end else if (bit_cnt_q >= LAST_I0) begin
                        state_d = FILL1;
                    end else begin
                        state_d = FILL0;
                    end
                end else if (expire_s) begin
                    state_d      = HOLD;
                    out_valid_d  = 1'b1;
                    out_padded_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d      = IDLE;
                    bit_cnt_d    = ZERO;
                    i0_d         = FILL_WORD;
                    i1_d         = FILL_WORD;
                    out_valid_d  = 1'b0;
                    out_padded_d = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d      = IDLE;
                bit_cnt_d    = ZERO;
                i0_d         = FILL_WORD;
                i1_d         = FILL_WORD;
                out_valid_d  = 1'b0;
                out_padded_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d != HOLD);
    end

    // State, counters and output word registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= ZERO;
            i0_q         <= FILL_WORD;
            i1_q         <= FILL_WORD;
            out_valid_q  <= 1'b0;
            out_padded_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            i0_q         <= i0_d;
            i1_q         <= i1_d;
            out_valid_q  <= out_valid_d;
            out_padded_q <= out_padded_d;
            in_ready_q   <= in_ready_d;
        end
    end

`ifdef MODEL_PACKER_PARITY_EN
    logic parity_q;
    logic parity_d;

    // Parity tracks the word registers edge for edge, so it holds with them in HOLD.
    always_comb begin
        parity_d = ^{i0_d, i1_d};
    end

    // Parity register.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= ^{FILL_WORD, FILL_WORD};
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.out_parity = parity_q;
`endif

    // in_ready is forced low while reset is held, then comes straight up.
    assign bus.in_ready   = in_ready_q & ~rst;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_i0     = i0_q;
    assign bus.out_i1     = i1_q;
    assign bus.out_padded = out_padded_q;

endmodule
